cla_prefix_sequencer: RTL and testbench

CLA_PREFIX_SEQUENCER -- requirements
Module: cla_prefix_sequencer

---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_prefix_sequencer_if.sv | 30 +++
 rtl/cla_prefix_level.sv | 37 +++
 rtl/cla_prefix_sequencer.sv | 121 ++++++++++++
 tb/tb_cla_prefix_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types for the prefix-carry sequencer: per-bit carry status, FSM states,
// default operand width and the per-bit status encoder.
package cla_pkg;

    localparam int DEFAULT_WIDTH = 64;
    // Wide enough for level numbers 0..6, which covers WIDTH up to 64.
    localparam int LEVEL_W       = 3;

    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b01,
        GEN  = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        SUM,
        DONE
    } state_t;

    function automatic status_t bit_status(input logic a, input logic b);
        if (a & b) begin
            return GEN;
        end else if (a ^ b) begin
            return PROP;
        end else begin
            return KILL;
        end
    endfunction

endpackage

// File: rtl/cla_prefix_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the
// prefix-carry sequencer (slave).
interface cla_prefix_sequencer_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/cla_prefix_level.sv
// One Kogge-Stone style prefix level: a propagating entry i inherits the status
// of entry i-2^level; kill/generate entries and entries below 2^level pass through.
module cla_prefix_level
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  status_t [WIDTH-1:0]   i_status,
    input  logic    [LEVEL_W-1:0] i_level,
    output status_t [WIDTH-1:0]   o_status
);

    status_t [WIDTH-1:0] w_cand [LEVELS];

    // Every level is built with constant offsets; the active one is selected below.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_hi
                assign w_cand[l][i] = (i_status[i] == PROP) ? i_status[i - (1 << l)]
                                                            : i_status[i];
            end else begin : g_lo
                assign w_cand[l][i] = i_status[i];
            end
        end
    end

    always_comb begin
        o_status = i_status;
        for (int l = 0; l < LEVELS; l++) begin
            if (i_level == LEVEL_W'(l)) begin
                o_status = w_cand[l];
            end
        end
    end

endmodule

// File: rtl/cla_prefix_sequencer.sv
// Multi-cycle carry-lookahead adder: captures per-bit status, resolves carries one
// prefix level per cycle, then registers sum/cout behind a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for operands (in_ready high once out of reset)
//   PREFIX | applying prefix level r_level to the status register
//   SUM    | forming sum/cout from resolved carries
//   DONE   | result held until out_ready
module cla_prefix_sequencer
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_prefix_sequencer_if.slave bus
);

    state_t                 r_state;
    logic                   r_armed;
    logic     [LEVEL_W-1:0] r_level;
    status_t  [WIDTH-1:0]   r_status;
    logic     [WIDTH-1:0]   r_axb;
    logic                   r_cin;
    logic     [WIDTH-1:0]   r_sum;
    logic                   r_cout;
    logic                   r_out_valid;

    status_t  [WIDTH-1:0]   w_capture;
    status_t  [WIDTH-1:0]   w_next_status;
    logic     [WIDTH-1:0]   w_carry;
    logic     [WIDTH-1:0]   w_sum;
    logic                   w_in_ready;

    // Carry-in is folded into bit 0 so the prefix network never needs to see it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_capture[i] = bit_status(bus.a[i], bus.b[i]);
        end
        if (w_capture[0] == PROP) begin
            w_capture[0] = bus.cin ? GEN : KILL;
        end
    end

    cla_prefix_level #(
        .WIDTH  (WIDTH),
        .LEVELS (LEVELS)
    ) u_level (
        .i_status (r_status),
        .i_level  (r_level),
        .o_status (w_next_status)
    );

    always_comb begin
        w_carry[0] = r_cin;
        for (int i = 1; i < WIDTH; i++) begin
            w_carry[i] = (r_status[i-1] == GEN);
        end
    end

    assign w_sum = r_axb ^ w_carry;

    // r_armed keeps in_ready low during reset and for nothing longer than one edge after.
    assign w_in_ready    = r_armed && (r_state == IDLE);
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_level     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_status[i] <= KILL;
            end
            r_axb       <= '0;
            r_cin       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && w_in_ready) begin
                        r_status <= w_capture;
                        r_level  <= '0;
                        r_axb    <= bus.a ^ bus.b;
                        r_cin    <= bus.cin;
                        r_state  <= PREFIX;
                    end
                end
                PREFIX: begin
                    r_status <= w_next_status;
                    r_level  <= r_level + LEVEL_W'(1);
                    if (r_level == LEVEL_W'(LEVELS - 1)) begin
                        r_state <= SUM;
                    end
                end
                SUM: begin
                    r_sum       <= w_sum;
                    r_cout      <= (r_status[WIDTH-1] == GEN);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_prefix_sequencer.sv
// Directed and randomised self-checking bench for cla_prefix_sequencer at WIDTH=64.
module tb_cla_prefix_sequencer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cla_prefix_sequencer_if #(.WIDTH(64)) bus ();

    cla_prefix_sequencer #(.WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accepting edge counts as edge 1; out_valid must be seen after edge 8.
    task automatic run_add(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                           input logic tc, input int stall, input bit disturb);
        logic [64:0] exp;
        int          lat;
        exp = {1'b0, ta} + {1'b0, tb_} + {64'd0, tc};
        @(negedge clk);
        check({tag, " in_ready"}, 65'(bus.in_ready), 65'd1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_;
        bus.cin      = tc;
        @(posedge clk);
        lat = 1;
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~ta;
        bus.b        = {$urandom, $urandom};
        bus.cin      = ~tc;
        check({tag, " busy"}, 65'(bus.busy), 65'd1);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, " latency"}, 65'(lat), 65'd8);
        check({tag, " result"}, {bus.cout, bus.sum}, exp);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (disturb) begin
                bus.in_valid = ~bus.in_valid;
                bus.a        = {$urandom, $urandom};
                bus.cin      = ~bus.cin;
            end
            @(posedge clk);
            #1;
            check({tag, " hold"}, {bus.cout, bus.sum}, exp);
            check({tag, " hold_vld_rdy"}, 65'({bus.out_valid, bus.in_ready}), 65'b10);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " release_vld_rdy"}, 65'({bus.out_valid, bus.in_ready}), 65'b01);
        check({tag, " retained"}, {bus.cout, bus.sum}, exp);
    endtask

    initial begin
        int          seen;
        logic [63:0] ra;
        logic [63:0] rb;
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 65'(bus.in_ready), 65'd0);
        check("rst busy", 65'(bus.busy), 65'd0);
        check("rst out_valid", 65'(bus.out_valid), 65'd0);
        check("rst result", {bus.cout, bus.sum}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre-edge in_ready", 65'(bus.in_ready), 65'd0);
        @(posedge clk);
        #1;
        check("post-rst in_ready", 65'(bus.in_ready), 65'd1);

        run_add("ones+1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 1'b0);
        run_add("0+0+c", 64'd0, 64'd0, 1'b1, 0, 1'b0);
        run_add("alt+c", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 2, 1'b0);
        run_add("max+max+c", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);
        run_add("stall20", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 20, 1'b1);
        run_add("after_stall", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 0, 1'b0);

        // Abort an operation while level 3 is being applied.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 64'hFFFF_FFFF_0000_FFFF;
        bus.b        = 64'h0000_0001_FFFF_0001;
        bus.cin      = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid busy", 65'(bus.busy), 65'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 65'(bus.busy), 65'd0);
        check("abort in_ready", 65'(bus.in_ready), 65'd0);
        check("abort result", {bus.cout, bus.sum}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort recover in_ready", 65'(bus.in_ready), 65'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort no out_valid", 65'(seen), 65'd0);
        run_add("fresh", 64'h1234, 64'h4321, 1'b0, 0, 1'b0);
        check("fresh sum", 65'(bus.sum), 65'h5555);

        for (int n = 0; n < 2000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_add("rand", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
